id_operand_fetch: RTL and testbench

- Read-side initiator for the dual-port register file, placed between the IF/ID register and the ID/EX register.
- Drives both regfile read ports (re1/raddr1, re2/raddr2) and consumes rdata1/rdata2.
- Overrides regfile data with in-flight EX/MEM results when a newer value exists.
- Detects load-use and pending-load hazards and stalls decode; registers resolved operands into a valid/ready output stage.

---
 rtl/id_operand_fetch_pkg.sv | 37 +++
 rtl/id_operand_fetch_src_resolve.sv | 59 +++++
 rtl/id_operand_fetch.sv | 131 +++++++++++++
 tb/tb_id_operand_fetch.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_operand_fetch_pkg.sv
// id_operand_fetch_pkg
//   Shared bus types, constants and the writer/source match helper used by the
//   operand fetch stage and its per-source resolver.
//   Optional feature macro: OPFETCH_FWD_EN (EX/MEM result forwarding).
package id_operand_fetch_pkg;

  localparam int RegNumLog2 = 5;
  localparam int RegBusW    = 32;
  localparam int InstAddrW  = 32;

  typedef logic [RegBusW-1:0]    RegBus;
  typedef logic [RegNumLog2-1:0] RegAddrBus;
  typedef logic [InstAddrW-1:0]  InstAddrBus;

  localparam RegBus ZeroWord    = '0;
  localparam logic  ReadEnable  = 1'b1;
  localparam logic  WriteEnable = 1'b1;

  // Contents of the ID/EX output register.
  typedef struct packed {
    InstAddrBus pc;
    RegBus      op1;
    RegBus      op2;
    RegAddrBus  rd;
    logic       wreg;
    logic       is_load;
  } idex_t;

  // A writer only matters for a source that is actually read and is not x0.
  function automatic logic src_match(input logic      use_src,
                                     input RegAddrBus src,
                                     input logic      wreg,
                                     input RegAddrBus waddr);
    return use_src && (src != '0) && (wreg == WriteEnable) && (waddr == src);
  endfunction

endpackage

// File: rtl/id_operand_fetch_src_resolve.sv
// opfetch_src_resolve
//   Resolves one source operand against the in-flight EX and MEM writers.
//   Ports:
//     use_src, addr        source operand used / register address
//     rdata                regfile read data for this source
//     ex_*, mem_*          writer info of the EX and MEM stages
//     value                resolved operand (0 when unused or x0)
//     hazard               operand cannot be resolved this cycle
//   Optional feature macro: OPFETCH_FWD_EN. Without it, any matching writer is
//   a hazard and the operand comes from the regfile only.
module opfetch_src_resolve
  import id_operand_fetch_pkg::*;
(
  input  logic      use_src,
  input  RegAddrBus addr,
  input  RegBus     rdata,
  input  logic      ex_wreg,
  input  logic      ex_is_load,
  input  RegAddrBus ex_waddr,
  input  RegBus     ex_wdata,
  input  logic      mem_wreg,
  input  logic      mem_load_pending,
  input  RegAddrBus mem_waddr,
  input  RegBus     mem_wdata,
  output RegBus     value,
  output logic      hazard
);

  logic ex_hit;
  logic mem_hit;
  logic src_live;

  assign ex_hit   = src_match(use_src, addr, ex_wreg, ex_waddr);
  assign mem_hit  = src_match(use_src, addr, mem_wreg, mem_waddr);
  assign src_live = use_src && (addr != '0);

`ifdef OPFETCH_FWD_EN
  always_comb begin
    value  = ZeroWord;
    hazard = (ex_hit && ex_is_load) || (mem_hit && mem_load_pending);
    // EX is the younger writer, so it shadows MEM on the same register.
    if (src_live) begin
      if (ex_hit)       value = ex_wdata;
      else if (mem_hit) value = mem_wdata;
      else              value = rdata;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{ex_is_load, ex_wdata, mem_load_pending, mem_wdata};

  always_comb begin
    value  = ZeroWord;
    hazard = ex_hit || mem_hit;
    if (src_live) value = rdata;
  end
`endif

endmodule

// File: rtl/id_operand_fetch.sv
// id_operand_fetch
//   Operand fetch between IF/ID and ID/EX: drives both regfile read ports,
//   resolves operands (with optional EX/MEM forwarding), stalls decode on
//   load hazards and registers the result into a valid/ready output stage.
//   Ports:
//     clk, rst, rdy                  clock, sync active-high reset, global ready
//     in_*                           decoded instruction, in_valid/in_ready
//     re1/raddr1, re2/raddr2, rdata* regfile read ports
//     ex_*, mem_*                    in-flight writer info
//     out_*                          ID/EX register, out_valid/out_ready
//     stall_cnt                      saturating count of hazard cycles
//   Optional feature macro: OPFETCH_FWD_EN (EX/MEM result forwarding).
module id_operand_fetch
  import id_operand_fetch_pkg::*;
#(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic                   in_use1,
  input  logic                   in_use2,
  input  logic [4:0]             in_rs1,
  input  logic [4:0]             in_rs2,
  input  logic [4:0]             in_rd,
  input  logic                   in_wreg,
  input  logic                   in_is_load,
  output logic                   re1,
  output logic                   re2,
  output logic [4:0]             raddr1,
  output logic [4:0]             raddr2,
  input  logic [31:0]            rdata1,
  input  logic [31:0]            rdata2,
  input  logic                   ex_wreg,
  input  logic                   ex_is_load,
  input  logic [4:0]             ex_waddr,
  input  logic [31:0]            ex_wdata,
  input  logic                   mem_wreg,
  input  logic                   mem_load_pending,
  input  logic [4:0]             mem_waddr,
  input  logic [31:0]            mem_wdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_pc,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [4:0]             out_rd,
  output logic                   out_wreg,
  output logic                   out_is_load,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  RegBus op1, op2;
  logic  haz1, haz2, hazard;
  logic  out_free, accept;

  idex_t                  stage_q, stage_d;
  logic                   valid_q, valid_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  opfetch_src_resolve u_src1 (
    .use_src(in_use1), .addr(in_rs1), .rdata(rdata1),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_load_pending(mem_load_pending),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .value(op1), .hazard(haz1)
  );

  opfetch_src_resolve u_src2 (
    .use_src(in_use2), .addr(in_rs2), .rdata(rdata2),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_load_pending(mem_load_pending),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .value(op2), .hazard(haz2)
  );

  assign hazard   = haz1 || haz2;
  assign out_free = !valid_q || out_ready;
  assign in_ready = rdy && !hazard && out_free;
  assign accept   = in_valid && in_ready;

  assign re1    = (rdy && in_valid && in_use1) ? ReadEnable : ~ReadEnable;
  assign re2    = (rdy && in_valid && in_use2) ? ReadEnable : ~ReadEnable;
  assign raddr1 = in_rs1;
  assign raddr2 = in_rs2;

  always_comb begin
    stage_d     = stage_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    if (accept) begin
      stage_d.pc      = in_pc;
      stage_d.op1     = op1;
      stage_d.op2     = op2;
      stage_d.rd      = in_rd;
      stage_d.wreg    = in_wreg;
      stage_d.is_load = in_is_load;
      valid_d         = 1'b1;
    end else if (out_free) begin
      // Drained or bubbled: data registers keep their last contents.
      valid_d = 1'b0;
    end
    if (in_valid && hazard && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q     <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else if (rdy) begin
      stage_q     <= stage_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = stage_q.pc;
  assign out_op1     = stage_q.op1;
  assign out_op2     = stage_q.op2;
  assign out_rd      = stage_q.rd;
  assign out_wreg    = stage_q.wreg;
  assign out_is_load = stage_q.is_load;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// tb_id_operand_fetch
//   Directed bench for id_operand_fetch. The stall counter is built 3 bits wide
//   so that saturation is reachable in a short run.
module tb_id_operand_fetch;

  localparam int CW = 3;

  logic        clk = 1'b0;
  logic        rst, rdy, in_valid, in_ready;
  logic [31:0] in_pc;
  logic        in_use1, in_use2;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_wreg, in_is_load;
  logic        re1, re2;
  logic [4:0]  raddr1, raddr2;
  logic [31:0] rdata1, rdata2;
  logic        ex_wreg, ex_is_load;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        mem_wreg, mem_load_pending;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wreg, out_is_load;
  logic [CW-1:0] stall_cnt;

  int vec   = 0;
  int fails = 0;
  int exp_stall = 0;

  always #5 clk = ~clk;

  id_operand_fetch #(.STALL_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_use1(in_use1), .in_use2(in_use2), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_rd(in_rd), .in_wreg(in_wreg), .in_is_load(in_is_load),
    .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2),
    .rdata1(rdata1), .rdata2(rdata2),
    .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .mem_wreg(mem_wreg), .mem_load_pending(mem_load_pending),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_wreg(out_wreg), .out_is_load(out_is_load), .stall_cnt(stall_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rdy = 1'b1; in_valid = 1'b0; in_pc = '0;
    in_use1 = 1'b0; in_use2 = 1'b0; in_rs1 = '0; in_rs2 = '0;
    in_rd = '0; in_wreg = 1'b0; in_is_load = 1'b0;
    rdata1 = '0; rdata2 = '0;
    ex_wreg = 1'b0; ex_is_load = 1'b0; ex_waddr = '0; ex_wdata = '0;
    mem_wreg = 1'b0; mem_load_pending = 1'b0; mem_waddr = '0; mem_wdata = '0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1; rdy = 1'b0;
    in_valid = 1'b1; in_pc = 32'hDEAD; rdata1 = 32'h1; in_use1 = 1'b1; in_rs1 = 5'd1;
    step(); step();
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    vec++; if (out_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    vec++; if (out_op1 !== 32'h0) begin fails++; $display("FAIL reset_op1: got %h want 0", out_op1); end
    vec++; if (stall_cnt !== 3'd0) begin fails++; $display("FAIL reset_stall: got %0d want 0", stall_cnt); end
    rst = 1'b0;
    clear_inputs();
    #1;
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h100; in_use1 = 1'b1; in_use2 = 1'b1;
    in_rs1 = 5'd5; in_rs2 = 5'd6; in_rd = 5'd7; in_wreg = 1'b1;
    rdata1 = 32'h11; rdata2 = 32'h22;
    #1;
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    vec++; if ({re1, re2} !== 2'b11) begin fails++; $display("FAIL basic_re: got %b want 11", {re1, re2}); end
    vec++; if ({raddr1, raddr2} !== {5'd5, 5'd6}) begin fails++; $display("FAIL basic_raddr: got %0d/%0d want 5/6", raddr1, raddr2); end
    step();
    vec++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    vec++; if (out_op1 !== 32'h11) begin fails++; $display("FAIL basic_op1: got %h want 11", out_op1); end
    vec++; if (out_op2 !== 32'h22) begin fails++; $display("FAIL basic_op2: got %h want 22", out_op2); end
    vec++; if ({out_pc, out_rd, out_wreg, out_is_load} !== {32'h100, 5'd7, 1'b1, 1'b0}) begin
      fails++; $display("FAIL basic_ctrl: got pc=%h rd=%0d w=%b l=%b want pc=100 rd=7 w=1 l=0", out_pc, out_rd, out_wreg, out_is_load); end
    in_valid = 1'b0;
    step();
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_ex_priority();
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h104; in_use1 = 1'b1; in_use2 = 1'b1;
    in_rs1 = 5'd5; in_rs2 = 5'd6; rdata1 = 32'h11; rdata2 = 32'h22;
    ex_wreg = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'hAA;
    mem_wreg = 1'b1; mem_waddr = 5'd5; mem_wdata = 32'hBB;
    #1;
`ifdef OPFETCH_FWD_EN
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL expri_in_ready: got %b want 1", in_ready); end
    step();
    vec++; if (out_op1 !== 32'hAA) begin fails++; $display("FAIL expri_op1: got %h want AA", out_op1); end
    vec++; if (out_op2 !== 32'h22) begin fails++; $display("FAIL expri_op2: got %h want 22", out_op2); end
`else
    vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL expri_in_ready: got %b want 0", in_ready); end
    step();
    exp_stall++;
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL expri_stall: got %0d want %0d", stall_cnt, exp_stall); end
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL expri_bubble: got %b want 0", out_valid); end
`endif
    clear_inputs();
    step();
  endtask

  task automatic test_load_use();
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h108; in_use2 = 1'b1; in_rs2 = 5'd6; rdata2 = 32'h77;
    in_rs1 = 5'd6; rdata1 = 32'h66;
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd6; ex_wdata = 32'hEE;
    #1;
    vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ld_in_ready: got %b want 0", in_ready); end
    step();
    exp_stall++;
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL ld_stall: got %0d want %0d", stall_cnt, exp_stall); end
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ld_bubble: got %b want 0", out_valid); end
    ex_wreg = 1'b0; ex_is_load = 1'b0; ex_waddr = '0;
    mem_wreg = 1'b1; mem_waddr = 5'd6; mem_wdata = 32'h33; mem_load_pending = 1'b0;
    #1;
`ifndef OPFETCH_FWD_EN
    vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ld_mem_in_ready: got %b want 0", in_ready); end
    step();
    exp_stall++;
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL ld_mem_stall: got %0d want %0d", stall_cnt, exp_stall); end
    mem_wreg = 1'b0; mem_waddr = '0; rdata2 = 32'h33;
    #1;
`endif
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ld_accept_ready: got %b want 1", in_ready); end
    step();
    vec++; if (out_op2 !== 32'h33) begin fails++; $display("FAIL ld_op2: got %h want 33", out_op2); end
    vec++; if (out_op1 !== 32'h0) begin fails++; $display("FAIL ld_op1_unused: got %h want 0", out_op1); end
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL ld_stall_hold: got %0d want %0d", stall_cnt, exp_stall); end
    // MEM load not yet returned is a hazard in both builds.
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h10C; in_use1 = 1'b1; in_rs1 = 5'd9;
    mem_wreg = 1'b1; mem_waddr = 5'd9; mem_load_pending = 1'b1; mem_wdata = 32'h44;
    #1;
    vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL pend_in_ready: got %b want 0", in_ready); end
    step();
    exp_stall++;
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL pend_stall: got %0d want %0d", stall_cnt, exp_stall); end
    clear_inputs();
    step();
  endtask

  task automatic test_zero_reg();
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h110; in_use1 = 1'b1; in_rs1 = 5'd0;
    in_use2 = 1'b0; in_rs2 = 5'd6; rdata1 = 32'h0; rdata2 = 32'h99;
    ex_wreg = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'hFF;
    mem_wreg = 1'b1; mem_waddr = 5'd6; mem_load_pending = 1'b1; mem_wdata = 32'h55;
    #1;
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL zero_in_ready: got %b want 1", in_ready); end
    vec++; if (re2 !== 1'b0) begin fails++; $display("FAIL zero_re2: got %b want 0", re2); end
    step();
    vec++; if (out_op1 !== 32'h0) begin fails++; $display("FAIL zero_op1: got %h want 0", out_op1); end
    vec++; if (out_op2 !== 32'h0) begin fails++; $display("FAIL zero_op2_unused: got %h want 0", out_op2); end
    vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL zero_stall: got %0d want %0d", stall_cnt, exp_stall); end
    clear_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    in_valid = 1'b1; in_pc = 32'h200; in_use1 = 1'b1; in_rs1 = 5'd3; rdata1 = 32'h1234; in_rd = 5'd4;
    out_ready = 1'b0;
    step();
    vec++; if ({out_valid, out_pc} !== {1'b1, 32'h200}) begin fails++; $display("FAIL bp_first: got v=%b pc=%h want v=1 pc=200", out_valid, out_pc); end
    in_pc = 32'h204; rdata1 = 32'h5678; in_rd = 5'd8;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      step();
      vec++; if ({out_valid, out_pc, out_op1, out_rd} !== {1'b1, 32'h200, 32'h1234, 5'd4}) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h op1=%h rd=%0d want v=1 pc=200 op1=1234 rd=4", i, out_valid, out_pc, out_op1, out_rd); end
    end
    out_ready = 1'b1;
    #1;
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    step();
    vec++; if ({out_valid, out_pc, out_op1} !== {1'b1, 32'h204, 32'h5678}) begin
      fails++; $display("FAIL bp_next: got v=%b pc=%h op1=%h want v=1 pc=204 op1=5678", out_valid, out_pc, out_op1); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    // Output holds pc 0x204 under stall; decode keeps presenting it.
    in_valid = 1'b1; out_ready = 1'b0;
    rst = 1'b1;
    step();
    vec++; if ({out_valid, out_pc} !== {1'b0, 32'h0}) begin fails++; $display("FAIL rststall_out: got v=%b pc=%h want v=0 pc=0", out_valid, out_pc); end
    vec++; if (stall_cnt !== 3'd0) begin fails++; $display("FAIL rststall_cnt: got %0d want 0", stall_cnt); end
    exp_stall = 0;
    rst = 1'b0;
    #1;
    vec++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rststall_ready: got %b want 1", in_ready); end
    step();
    vec++; if ({out_valid, out_pc} !== {1'b1, 32'h204}) begin fails++; $display("FAIL rststall_replay: got v=%b pc=%h want v=1 pc=204", out_valid, out_pc); end
  endtask

  task automatic test_rdy_low();
    clear_inputs();
    rdy = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h300; in_use1 = 1'b1; in_use2 = 1'b1; in_rs1 = 5'd5; in_rs2 = 5'd2;
    ex_wreg = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd5;
    #1;
    vec++; if ({re1, re2, in_ready} !== 3'b000) begin fails++; $display("FAIL rdy_ports: got re=%b%b rdy=%b want 000", re1, re2, in_ready); end
    for (int i = 0; i < 2; i++) begin
      step();
      vec++; if ({out_valid, out_pc, stall_cnt} !== {1'b1, 32'h204, 3'd0}) begin
        fails++; $display("FAIL rdy_freeze[%0d]: got v=%b pc=%h cnt=%0d want v=1 pc=204 cnt=0", i, out_valid, out_pc, stall_cnt); end
    end
    rdy = 1'b1;
  endtask

  task automatic test_saturation();
    // Load hazard left asserted from the previous scenario.
    for (int i = 0; i < 9; i++) begin
      step();
      exp_stall = (exp_stall == 7) ? 7 : exp_stall + 1;
      vec++; if (stall_cnt !== CW'(exp_stall)) begin fails++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, stall_cnt, exp_stall); end
    end
    vec++; if (out_valid !== 1'b0) begin fails++; $display("FAIL sat_bubble: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ex_priority();
    test_load_use();
    test_zero_reg();
    test_back_to_back();
    test_reset_mid_stall();
    test_rdy_low();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

endmodule
